// File: rtl/corr_readout_pkg.sv
// Shared types and helpers for the correlator readout: streamer states,
// frame sync byte and bytes-per-count sizing.
package corr_readout_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    PAY  = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bytes needed to carry one count, rounded up to whole bytes.
  function automatic int calc_bpw(input int resolution);
    return (resolution + 7) / 8;
  endfunction

endpackage

// File: rtl/corr_frame_timer.sv
// Integration frame timer: counts enabled clocks up to integration_len,
// strobes capture on the terminal count and registers clear_acc after it.
module corr_frame_timer #(
  parameter int LEN_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [LEN_WIDTH-1:0] integration_len,
  output logic                 capture,
  output logic                 clear_acc
);

  logic [LEN_WIDTH-1:0] cnt_r;
  logic                 out_of_range_s;
  logic                 terminal_s;

  // A length of zero always reads as out of range, which parks the counter.
  always_comb begin
    out_of_range_s = (cnt_r >= integration_len);
    if (out_of_range_s) begin
      terminal_s = 1'b0;
    end else begin
      terminal_s = (cnt_r == (integration_len - LEN_WIDTH'(1)));
    end
    capture = enable && terminal_s;
  end

  // Counter state and the delayed accumulator clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= '0;
      clear_acc <= 1'b0;
    end else begin
      clear_acc <= capture;
      if (out_of_range_s) begin
        cnt_r <= '0;
      end else if (capture) begin
        cnt_r <= '0;
      end else if (enable) begin
        cnt_r <= cnt_r + LEN_WIDTH'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/corr_readout.sv
// Correlator readout: snapshots the accumulator bus each frame and streams it
// as sync, seq, payload bytes. CORR_READOUT_CHECKSUM_EN appends an XOR checksum.
module corr_readout #(
  parameter int NUM_CHANNELS = 8,
  parameter int RESOLUTION   = 24,
  parameter int LEN_WIDTH    = 24
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [LEN_WIDTH-1:0]                integration_len,
  input  logic [NUM_CHANNELS*RESOLUTION*2-1:0] pulses,
  output logic                                clear_acc,
  output logic [7:0]                          out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                overrun,
  output logic [7:0]                          seq
);

  import corr_readout_pkg::*;

  localparam int BPW     = calc_bpw(RESOLUTION);
  localparam int PW      = NUM_CHANNELS * RESOLUTION * 2;
  localparam int PAY_LEN = NUM_CHANNELS * 2 * BPW;
  localparam int IDX_W   = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAY_LEN - 1);

  state_t           state_r;
  logic [PW-1:0]    shadow_r;
  logic [7:0]       seq_r;
  logic             overrun_r;
  logic             valid_r;
  logic [7:0]       data_r;
  logic [IDX_W-1:0] idx_r;

  logic             capture_s;
  logic             hs_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [7:0]       pay_byte_s;
  logic [7:0]       pay_bytes_s [PAY_LEN];

  corr_frame_timer #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_timer (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .integration_len (integration_len),
    .capture         (capture_s),
    .clear_acc       (clear_acc)
  );

  assign hs_s      = valid_r && out_ready;
  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign overrun   = overrun_r;
  assign seq       = seq_r;

  // Shadow viewed as a flat byte list: count c (real/imag interleaved), MSB byte first.
  always_comb begin
    logic [BPW*8-1:0] ext;
    ext = '0;
    for (int c = 0; c < 2 * NUM_CHANNELS; c++) begin
      ext = '0;
      ext[RESOLUTION-1:0] = shadow_r[c*RESOLUTION +: RESOLUTION];
      for (int b = 0; b < BPW; b++) begin
        pay_bytes_s[c*BPW + b] = ext[(BPW-1-b)*8 +: 8];
      end
    end
  end

  // Index of the payload byte to load on the next handshake.
  always_comb begin
    if (state_r == PAY && idx_r != LAST_IDX) begin
      sel_idx_s = idx_r + IDX_W'(1);
    end else begin
      sel_idx_s = '0;
    end
    pay_byte_s = pay_bytes_s[sel_idx_s];
  end

`ifdef CORR_READOUT_CHECKSUM_EN
  logic [7:0] csum_r;

  // Running XOR of every byte already handed to the sink in this frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_r <= 8'h00;
    end else if (capture_s && state_r == IDLE) begin
      csum_r <= 8'h00;
    end else if (hs_s) begin
      csum_r <= csum_r ^ data_r;
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  // Streamer FSM; out_data is loaded only on a handshake so it holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      shadow_r  <= '0;
      seq_r     <= 8'h00;
      overrun_r <= 1'b0;
      valid_r   <= 1'b0;
      data_r    <= 8'h00;
      idx_r     <= '0;
    end else begin
      if (capture_s && state_r != IDLE) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            shadow_r <= pulses;
            seq_r    <= seq_r + 8'd1;
            data_r   <= SYNC_BYTE;
            valid_r  <= 1'b1;
            state_r  <= HDR;
          end
        end
        HDR: begin
          if (hs_s) begin
            data_r  <= seq_r;
            state_r <= SEQ;
          end
        end
        SEQ: begin
          if (hs_s) begin
            data_r  <= pay_byte_s;
            idx_r   <= '0;
            state_r <= PAY;
          end
        end
        PAY: begin
          if (hs_s) begin
            if (idx_r == LAST_IDX) begin
`ifdef CORR_READOUT_CHECKSUM_EN
              data_r  <= csum_r ^ data_r;
              state_r <= CHK;
`else
              valid_r <= 1'b0;
              state_r <= IDLE;
`endif
            end else begin
              data_r <= pay_byte_s;
              idx_r  <= idx_r + IDX_W'(1);
            end
          end
        end
        CHK: begin
          if (hs_s) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/corr_readout.md
# corr_readout

Downstream readout stage for the correlator accumulator bus. Every `integration_len` enabled clocks it snapshots the full packed `pulses` vector into a shadow register and pulses `clear_acc` to restart integration. It then streams the frame as bytes over a valid/ready handshake toward the host link (UART/USB FIFO). Frame format: sync, sequence, payload, optional checksum.

## Interface
- `NUM_CHANNELS`, default 8: accumulator channels (baselines × lags); each channel carries a real and an imaginary count.
- `RESOLUTION`, default 24: bits per count; the payload bus is `NUM_CHANNELS*RESOLUTION*2` wide.
- `LEN_WIDTH`, default 24: width of `integration_len`.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `enable`, input, 1: integration counter advances only when high.
- `integration_len`, input, `LEN_WIDTH`: clocks per frame; 0 disables framing.
- `pulses`, input, `NUM_CHANNELS*RESOLUTION*2`: correlator accumulators. Channel k real is at `[k*2R +: R]`, imag at `[k*2R+R +: R]`, where R = `RESOLUTION`.
- `clear_acc`, output, 1: one-cycle pulse, OR'd into the correlator reset.
- `out_data`, output, 8: stream byte.
- `out_valid`, output, 1: byte valid.
- `out_ready`, input, 1: sink accepts the byte.
- `overrun`, output, 1: sticky; a frame was dropped because the streamer was busy.
- `seq`, output, 8: sequence number of the last captured frame.

## Operation
- BPW = ceil(RESOLUTION/8) bytes per count. Each count is zero-extended to BPW*8 bits and sent MSB byte first.
- Frame byte order:
  1. `0xA5`
  2. `seq`
  3. For k = 0..NUM_CHANNELS-1: real(k) bytes, then imag(k) bytes.
  4. Checksum (when configured).
- Frame length is 2 + NUM_CHANNELS*2*BPW bytes, +1 with the checksum.
- Frame timer:
  - Counter `cnt` increments when `enable` is high and `integration_len` != 0.
  - On `cnt == integration_len-1` (terminal) with `enable` high: `cnt` returns to 0 and a capture event fires.
  - `enable` low holds `cnt`.
  - A change to `integration_len` takes effect at once. If `cnt` is already ≥ the new `integration_len`, `cnt` resets to 0 without firing a capture.
- Capture event:
  - `clear_acc` is always asserted in the following cycle.
  - State IDLE: shadow ← `pulses`, `seq` ← `seq`+1, go to HDR.
  - Any other state: shadow and `seq` are untouched, `overrun` ← 1, and the in-flight frame continues.
- States:
  - IDLE → HDR on capture.
  - HDR → SEQ on handshake.
  - SEQ → PAY on handshake.
  - PAY walks byte index 0..NUM_CHANNELS*2*BPW-1; on the last handshake it goes to CHK (or to IDLE without the checksum).
  - CHK → IDLE on handshake.
- Handshake:
  - A transfer happens when `out_valid && out_ready`.
  - While `out_valid` is high and `out_ready` is low, `out_data` and `out_valid` hold stable.
  - `out_valid` never drops without a transfer, except on `reset`.

## Timing
- Reset values: `clear_acc` 0, `out_valid` 0, `out_data` 0x00, `overrun` 0, `seq` 0, `cnt` 0, state IDLE.
- Reset mid-frame: in the next cycle, state is IDLE and `out_valid` is 0, with no completion. This is the only legal valid-drop.
- Capture at cycle T:
  - Shadow is loaded with the `pulses` value present at T.
  - `clear_acc` is high during T+1. Correlator input during T+1 is lost by design.
  - `out_valid` is high with 0xA5 at T+1.
- With `out_ready` held high: one byte per cycle, no bubbles, and the frame's last byte is at T+1+len-1.
- The first capture after reset occurs after `integration_len` enabled cycles.
- Capture coinciding with the final handshake (CHK→IDLE or PAY→IDLE): the state is not IDLE at T, so the capture counts as overrun.
- `overrun` clears only on `reset`.

## Configuration
- `CORR_READOUT_CHECKSUM_EN` defined: append the XOR of all preceding frame bytes, sync and seq included.
- Not defined: no CHK state, and the frame ends after the last payload byte.

## Structure
- Package `corr_readout_pkg` holds:
  - the state enum (IDLE, HDR, SEQ, PAY, CHK);
  - `SYNC_BYTE = 8'hA5`;
  - a function computing BPW from RESOLUTION.
- Sub-module `corr_frame_timer` owns `cnt`, terminal detection and `clear_acc`, and outputs a one-cycle `capture` strobe.
- Payload byte select: index → channel, real/imag, byte within count. Use a registered mux on the shadow, updated on handshake, to meet timing on wide buses.

## Test plan
All cases use NUM_CHANNELS=2 and RESOLUTION=24 (BPW=3) unless stated otherwise.
- Basic frame: `integration_len`=4, `out_ready`=1, ch0=(0x000102, 0x000304), ch1=(0x0A0B0C, 0xFFFFFF).
  - `clear_acc` pulses at cycle 5.
  - Bytes: A5 01 00 01 02 00 03 04 0A 0B 0C FF FF FF, then the checksum (XOR of all preceding bytes) when enabled.
- Backpressure: `out_ready` toggling 1,0,0,1 → every byte appears exactly once, and `out_data` is stable while stalled.
- Overrun: `integration_len`=3 with `out_ready`=0.
  - 2nd capture → `overrun`=1, `seq` stays 1, the frame still completes with its original data.
  - `clear_acc` still pulses at every capture.
- `enable` gating: `enable` low for 10 cycles mid-count → capture is delayed by exactly 10 cycles.
- `integration_len`=0 → no `clear_acc` and no `out_valid` for 100 cycles.
- Reset at the 5th payload byte → `out_valid`=0, `seq`=0, `overrun`=0 in the next cycle. The next frame starts with A5 01.
